// File: rtl/pkg_tpu.sv
// Shared TPU types: lane data word, lane bus, and the lane transmitter FSM states.
package pkg_tpu;

  localparam int unsigned NUM_LANES = 16;
  localparam int unsigned DATA_W    = 16;

  typedef logic [DATA_W-1:0] data_t;
  typedef data_t [NUM_LANES-1:0] lane_t;

  typedef enum logic [1:0] {
    StIdle,
    StSend,
    StFlush
  } send_state_e;

endpackage

// File: rtl/lane_send_fifo.sv
// Circular transmit buffer with a combinational head read and a synchronous clear.
module lane_send_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [PTR_W:0]   count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wptr_q, rptr_q;
  logic [PTR_W:0]   count_q, count_d;

  // Callers only assert push/pop when legal, so no full/empty guarding here.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else begin
      case ({push, pop})
        2'b10:   count_d = count_q + (PTR_W+1)'(1);
        2'b01:   count_d = count_q - (PTR_W+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (clear) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + PTR_W'(1);
      if (pop)  rptr_q <= rptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push && !clear) mem[wptr_q] <= wdata;
  end

  assign rdata = mem[rptr_q];
  assign count = count_q;

endmodule

// File: rtl/lane_send.sv
// Lane transmitter: buffers operand pushes and presents the head entry on one lane-bus slot
// until every destination lane has acknowledged it.
module lane_send
  import pkg_tpu::*;
#(
  parameter int unsigned LANE_ID   = 0,
  parameter int unsigned NUM_LANES = 16,
  parameter int unsigned DEPTH     = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 I_Req,
  input  logic [NUM_LANES-1:0] I_Dst_Mask,
  input  data_t                I_Src_Data1,
  input  data_t                I_Src_Data2,
  input  data_t                I_Src_Data3,
  output logic                 O_Ready,
  output logic                 O_Lane_Valid,
  output logic [NUM_LANES-1:0] O_Lane_Mask,
  output lane_t                O_Lane_Data_Src1,
  output lane_t                O_Lane_Data_Src2,
  output lane_t                O_Lane_Data_Src3,
  input  logic [NUM_LANES-1:0] I_Lane_Ack,
  input  logic                 I_Flush,
  output logic                 O_Ovf,
  output logic                 O_Busy
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [NUM_LANES-1:0] mask;
    data_t                src1;
    data_t                src2;
    data_t                src3;
  } entry_t;

  entry_t               wr_entry, head;
  logic [CNT_W-1:0]     count;
  send_state_e          state_q;
  logic [NUM_LANES-1:0] acked_q, pending;
  logic                 ovf_q, in_flush, push_req, do_push, do_pop;

  assign wr_entry = '{mask: I_Dst_Mask, src1: I_Src_Data1, src2: I_Src_Data2, src3: I_Src_Data3};

  lane_send_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .clear (I_Flush),
    .push  (do_push),
    .pop   (do_pop),
    .wdata (wr_entry),
    .rdata (head),
    .count (count)
  );

  // Pending is derived from the head's stored mask minus the acks seen so far, so a new head
  // automatically starts with its full mask once acked_q is cleared on pop.
  assign in_flush     = (state_q == StFlush);
  assign O_Ready      = (count < CNT_W'(DEPTH));
  assign O_Lane_Valid = (count != '0) && !in_flush;
  assign pending      = head.mask & ~acked_q;
  assign O_Lane_Mask  = O_Lane_Valid ? pending : '0;
  assign do_pop       = O_Lane_Valid && !I_Flush && ((pending & ~I_Lane_Ack) == '0);
  assign push_req     = I_Req && (I_Dst_Mask != '0) && !I_Flush && !in_flush;
  assign do_push      = push_req && (O_Ready || do_pop);
  assign O_Ovf        = ovf_q;
  assign O_Busy       = (count != '0) || (state_q != StIdle);

  always_comb begin
    O_Lane_Data_Src1 = '0;
    O_Lane_Data_Src2 = '0;
    O_Lane_Data_Src3 = '0;
    if (O_Lane_Valid) begin
      O_Lane_Data_Src1[LANE_ID] = head.src1;
      O_Lane_Data_Src2[LANE_ID] = head.src2;
      O_Lane_Data_Src3[LANE_ID] = head.src3;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      acked_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (push_req && !do_push) ovf_q <= 1'b1;

      if (I_Flush || do_pop) begin
        acked_q <= '0;
      end else if (O_Lane_Valid) begin
        acked_q <= acked_q | (I_Lane_Ack & head.mask);
      end

      if (I_Flush) begin
        state_q <= StFlush;
      end else begin
        case (state_q)
          StIdle:  if (do_push) state_q <= StSend;
          StSend:  if (do_pop && (count == CNT_W'(1)) && !do_push) state_q <= StIdle;
          StFlush: state_q <= StIdle;
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lane_send.sv
// Randomised and directed bench for lane_send: per-cycle output model plus a delivery scoreboard.
module tb_lane_send;
  import pkg_tpu::*;

  localparam int unsigned LID   = 2;
  localparam int unsigned NL    = 16;
  localparam int          DEPTH = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          I_Req, I_Flush;
  logic [NL-1:0] I_Dst_Mask, I_Lane_Ack, O_Lane_Mask;
  data_t         I_Src_Data1, I_Src_Data2, I_Src_Data3;
  logic          O_Ready, O_Lane_Valid, O_Ovf, O_Busy;
  lane_t         O_Lane_Data_Src1, O_Lane_Data_Src2, O_Lane_Data_Src3;

  lane_send #(
    .LANE_ID   (LID),
    .NUM_LANES (NL),
    .DEPTH     (DEPTH)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .I_Req            (I_Req),
    .I_Dst_Mask       (I_Dst_Mask),
    .I_Src_Data1      (I_Src_Data1),
    .I_Src_Data2      (I_Src_Data2),
    .I_Src_Data3      (I_Src_Data3),
    .O_Ready          (O_Ready),
    .O_Lane_Valid     (O_Lane_Valid),
    .O_Lane_Mask      (O_Lane_Mask),
    .O_Lane_Data_Src1 (O_Lane_Data_Src1),
    .O_Lane_Data_Src2 (O_Lane_Data_Src2),
    .O_Lane_Data_Src3 (O_Lane_Data_Src3),
    .I_Lane_Ack       (I_Lane_Ack),
    .I_Flush          (I_Flush),
    .O_Ovf            (O_Ovf),
    .O_Busy           (O_Busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [NL-1:0] mask;
    data_t         s1, s2, s3;
  } ent_t;

  ent_t          mq[$];     // reference buffer contents, head first
  ent_t          sb_q[$];   // expected deliveries, consumed by the monitor
  logic [NL-1:0] m_acked;
  logic          m_ovf;
  bit            m_flush;
  int            checks = 0;
  int            errors = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void chk_lane(string name, lane_t act, lane_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    mq.delete();
    sb_q.delete();
    m_acked = '0;
    m_ovf   = 1'b0;
    m_flush = 1'b0;
  endfunction

  // One clock cycle: drive, compare outputs against the model, then advance the model.
  task automatic step(input logic req, input logic [NL-1:0] msk, input data_t d1,
                      input logic [NL-1:0] ack, input logic fl);
    ent_t          e;
    logic          vld, pop;
    logic [NL-1:0] pend;
    lane_t         x1, x2, x3;
    @(negedge clock);
    e.mask = msk;
    e.s1   = d1;
    e.s2   = data_t'($urandom);
    e.s3   = data_t'($urandom);
    I_Req = req; I_Dst_Mask = msk; I_Lane_Ack = ack; I_Flush = fl;
    I_Src_Data1 = e.s1; I_Src_Data2 = e.s2; I_Src_Data3 = e.s3;
    #1;
    vld  = !m_flush && (mq.size() > 0);
    pend = vld ? (mq[0].mask & ~m_acked) : '0;
    x1 = '0; x2 = '0; x3 = '0;
    if (vld) begin
      x1[LID] = mq[0].s1;
      x2[LID] = mq[0].s2;
      x3[LID] = mq[0].s3;
    end
    chk("ready", 64'(O_Ready), 64'(mq.size() < DEPTH));
    chk("valid", 64'(O_Lane_Valid), 64'(vld));
    chk("mask", 64'(O_Lane_Mask), 64'(pend));
    chk("ovf", 64'(O_Ovf), 64'(m_ovf));
    chk("busy", 64'(O_Busy), 64'(mq.size() > 0 || m_flush));
    chk_lane("src1", O_Lane_Data_Src1, x1);
    chk_lane("src2", O_Lane_Data_Src2, x2);
    chk_lane("src3", O_Lane_Data_Src3, x3);
    if (fl) begin
      mq.delete();
      sb_q.delete();
      m_acked = '0;
      m_flush = 1'b1;
    end else if (m_flush) begin
      m_flush = 1'b0;
    end else begin
      pop = vld && ((pend & ~ack) == '0);
      if (req && msk != '0) begin
        if (mq.size() < DEPTH || pop) begin
          mq.push_back(e);
          sb_q.push_back(e);
        end else begin
          m_ovf = 1'b1;
        end
      end
      if (pop) begin
        mq.delete(0);
        m_acked = '0;
      end else if (vld) begin
        m_acked = m_acked | (ack & mq[0].mask);
      end
    end
  endtask

  // Delivery monitor: whenever the DUT completes an entry, it must be the oldest expected one.
  always @(negedge clock) begin : monitor
    ent_t h;
    #2;
    if (!reset && O_Lane_Valid && !I_Flush && ((O_Lane_Mask & ~I_Lane_Ack) == '0)) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_pop", 64'(1), 64'(0));
      end else begin
        h = sb_q.pop_front();
        chk("sb_src1", 64'(O_Lane_Data_Src1[LID]), 64'(h.s1));
        chk("sb_src2", 64'(O_Lane_Data_Src2[LID]), 64'(h.s2));
        chk("sb_src3", 64'(O_Lane_Data_Src3[LID]), 64'(h.s3));
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    I_Req = 1'b0; I_Flush = 1'b0; I_Dst_Mask = '0; I_Lane_Ack = '0;
    I_Src_Data1 = '0; I_Src_Data2 = '0; I_Src_Data3 = '0;
    model_reset();
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    do_reset();
    step(1'b0, '0, '0, '0, 1'b0);

    // Single push to two lanes, acked one lane per cycle
    step(1'b1, 16'h0003, 16'h0011, '0, 1'b0);
    step(1'b0, '0, '0, 16'h0001, 1'b0);
    chk("r22_mask_n1", 64'(O_Lane_Mask), 64'h3);
    chk("r22_data_n1", 64'(O_Lane_Data_Src1[LID]), 64'h11);
    step(1'b0, '0, '0, 16'h0002, 1'b0);
    chk("r22_mask_n2", 64'(O_Lane_Mask), 64'h2);
    step(1'b0, '0, '0, '0, 1'b0);
    chk("r22_valid_n3", 64'(O_Lane_Valid), 64'h0);

    // Zero-mask request is a no-op
    step(1'b1, '0, 16'h00aa, '0, 1'b0);
    step(1'b0, '0, '0, '0, 1'b0);
    chk("zero_mask_busy", 64'(O_Busy), 64'h0);

    // Fill, overflow, then drain in order
    for (int i = 0; i < 4; i++) step(1'b1, 16'h0001 << i, data_t'(16'h100 + i), '0, 1'b0);
    step(1'b1, 16'h0010, 16'h0bad, '0, 1'b0);
    chk("r23_ready_full", 64'(O_Ready), 64'h0);
    step(1'b0, '0, '0, 16'hffff, 1'b0);
    chk("r23_ovf", 64'(O_Ovf), 64'h1);
    for (int i = 0; i < 4; i++) step(1'b0, '0, '0, 16'hffff, 1'b0);
    chk("r23_ovf_sticky", 64'(O_Ovf), 64'h1);

    // Full buffer with a same-cycle pop accepts the push
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 16'h0003, data_t'($urandom), '0, 1'b0);
    step(1'b1, 16'h0005, 16'h0777, 16'h0003, 1'b0);
    step(1'b0, '0, '0, '0, 1'b0);
    chk("r24_ready", 64'(O_Ready), 64'h0);
    chk("r24_ovf", 64'(O_Ovf), 64'h0);
    for (int i = 0; i < 4; i++) step(1'b0, '0, '0, 16'h0007, 1'b0);

    // Stray ack on a lane outside the pending mask
    step(1'b1, 16'h0004, 16'h0044, '0, 1'b0);
    step(1'b0, '0, '0, 16'h0008, 1'b0);
    step(1'b0, '0, '0, 16'h0004, 1'b0);
    chk("r25_still_valid", 64'(O_Lane_Valid), 64'h1);
    step(1'b0, '0, '0, '0, 1'b0);
    chk("r25_popped", 64'(O_Lane_Valid), 64'h0);

    // Flush wins over a simultaneous push
    for (int i = 0; i < 3; i++) step(1'b1, 16'h0002, data_t'($urandom), '0, 1'b0);
    step(1'b1, 16'h0002, 16'h0999, 16'h0002, 1'b1);
    step(1'b0, '0, '0, '0, 1'b0);
    chk("r26_flush_valid", 64'(O_Lane_Valid), 64'h0);
    chk("r26_flush_busy", 64'(O_Busy), 64'h1);
    step(1'b0, '0, '0, '0, 1'b0);
    chk("r26_idle_busy", 64'(O_Busy), 64'h0);

    // Asynchronous reset mid-transfer
    step(1'b1, 16'h0006, data_t'($urandom), '0, 1'b0);
    step(1'b1, 16'h0001, data_t'($urandom), 16'h0002, 1'b0);
    @(negedge clock);
    I_Req = 1'b0; I_Lane_Ack = '0;
    #3;
    reset = 1'b1;
    #1;
    chk("rst_valid", 64'(O_Lane_Valid), 64'h0);
    chk("rst_mask", 64'(O_Lane_Mask), 64'h0);
    chk("rst_ready", 64'(O_Ready), 64'h1);
    chk("rst_busy", 64'(O_Busy), 64'h0);
    chk("rst_ovf", 64'(O_Ovf), 64'h0);
    chk_lane("rst_src1", O_Lane_Data_Src1, '0);
    model_reset();
    @(negedge clock);
    reset = 1'b0;
    step(1'b0, '0, '0, 16'hffff, 1'b0);
    step(1'b0, '0, '0, '0, 1'b0);

    // Randomised traffic on lanes 0..3
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 1)), NL'($urandom_range(0, 15)), data_t'($urandom),
           NL'($urandom_range(0, 15)), ($urandom_range(0, 39) == 0));
    end
    for (int i = 0; i < 8; i++) step(1'b0, '0, '0, 16'h000f, 1'b0);
    chk("drain_empty", 64'(sb_q.size()), 64'(0));

    @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lane_send.md
LANE_SEND -- requirements
Module: lane_send

Interface
REQ-001 SHALL have parameter LANE_ID, default 0, meaning the index of the lane slot this transmitter drives.
REQ-002 SHALL have parameter NUM_LANES, default 16, meaning the lane count; selects are 4 bits.
REQ-003 SHALL have parameter DEPTH, default 4, meaning the number of transmit buffer entries (power of two, at least 2).
REQ-004 SHALL have the following ports:
  clock  in  1  system clock.
  reset  in  1  asynchronous, active-high reset.
  I_Req  in  1  push request.
  I_Dst_Mask  in  NUM_LANES  destination lanes that must consume the entry.
  I_Src_Data1/2/3  in  data_t each  operands captured on push.
  O_Ready  out  1  buffer can accept a push this cycle.
  O_Lane_Valid  out  1  head entry is presented on the lane bus.
  O_Lane_Mask  out  NUM_LANES  pending (not yet acknowledged) destinations of the head entry.
  O_Lane_Data_Src1/2/3  out  lane_t each  lane bus; only slot [LANE_ID] driven, all other slots '0.
  I_Lane_Ack  in  NUM_LANES  per-destination consume acknowledge from receiving lanes.
  I_Flush  in  1  discard all buffered entries.
  O_Ovf  out  1  sticky overflow error flag.
  O_Busy  out  1  buffer non-empty or FSM not IDLE.

Function
REQ-005 Push SHALL occur when I_Req=1, I_Dst_Mask!=0 and (O_Ready=1 or a pop occurs in the same cycle).
REQ-006 I_Req=1 with I_Dst_Mask=0 SHALL be a no-op (nothing stored, no error).
REQ-007 I_Req=1 with a non-zero mask, on a full buffer with no same-cycle pop, SHALL drop the push and set O_Ovf; O_Ovf clears only on reset.
REQ-008 O_Ready SHALL be 1 when count < DEPTH; it is combinational from count only, not from the acks.
REQ-009 Latency: an entry pushed into an empty buffer in cycle N SHALL appear with O_Lane_Valid=1 in cycle N+1.
REQ-010 While O_Lane_Valid=1, slot [LANE_ID] of each O_Lane_Data_SrcK SHALL carry head SrcK; when O_Lane_Valid=0 it SHALL be '0.
REQ-011 The pending mask is loaded from the entry's stored mask when the entry becomes head. Each cycle it SHALL be updated as pending & ~I_Lane_Ack.
REQ-012 Acks for lanes not in the pending mask SHALL be ignored, as SHALL any ack while O_Lane_Valid=0.
REQ-013 Pop SHALL occur in the cycle where (pending & ~I_Lane_Ack)==0. The next entry SHALL be presented the following cycle, giving back-to-back throughput of 1 entry/cycle when every destination acks immediately.
REQ-014 FSM states SHALL be IDLE, SEND and FLUSH:
  IDLE->SEND on push.
  SEND->IDLE on pop of the last entry with no same-cycle push.
  any->FLUSH on I_Flush.
  FLUSH->IDLE after one cycle.
REQ-015 In FLUSH, the buffer SHALL be emptied, O_Lane_Valid=0, and pushes and acks ignored. I_Flush has priority over a simultaneous push or pop.
REQ-016 Read and write pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH. Count SHALL be log2(DEPTH)+1 bits.

Reset
REQ-017 On reset assertion, all outputs SHALL go to 0 immediately (O_Ready to 1), pointers and count to 0, FSM to IDLE and O_Ovf to 0.
REQ-018 Reset mid-transfer SHALL discard the buffered entries with no partial presentation after release.
REQ-019 Buffer data storage SHALL need no reset.

Structure
REQ-020 data_t, lane_t and the NUM_LANES constant SHALL come from pkg_tpu. The FSM state enum SHALL be added to pkg_tpu.
REQ-021 Storage SHALL be one sub-module, lane_send_fifo (parameterised width/depth, push/pop/count), with the FSM and mask tracking in lane_send.

Verification
REQ-022 Single push: LANE_ID=2, push Src1=0x11, mask=0x0003, ack lane0 in cycle N+1 and lane1 in cycle N+2 -> valid during N+1..N+2, mask goes 0x0003->0x0002, pop at N+2, valid=0 at N+3.
REQ-023 Fill: 4 pushes with no ack -> O_Ready=0; a 5th push -> dropped, O_Ovf=1; then acking all -> entries delivered in FIFO order with O_Ovf still 1.
REQ-024 Full with same-cycle pop: buffer full, head fully acked while I_Req=1 -> push accepted, count stays 4, O_Ovf=0.
REQ-025 Stray ack: head mask=0x0004 with I_Lane_Ack=0x0008 -> no pop; then ack 0x0004 -> pop.
REQ-026 Flush and reset: 3 entries buffered, I_Flush together with I_Req -> next cycle FLUSH, count=0, valid=0, then IDLE. Reset asserted mid-SEND -> outputs 0 asynchronously.
